// File: rtl/ttt_host_driver_if.sv
// ttt_host_driver_if: host/device-facing bundle for the TTT host driver.
//   cmd_*   : host command handshake (valid/ready) with 4-bit opcode and 12-bit payload
//   pkt_*   : packet driven to the device inputs ({ui_in, uio_in})
//   status_in : raw device uo_out ([7:4] proc, [3:2] start/stop, [1:0] stage)
//   evt_*   : event FIFO head, pop handshake and sticky overflow flag
//   cmd_error : one-cycle pulse on a dropped reserved opcode or a timed-out gated command
// The slave modport is the driver; the master modport is the host/device environment.
interface ttt_host_driver_if;
   localparam int unsigned OP_W     = 4;
   localparam int unsigned DATA_W   = 12;
   localparam int unsigned STATUS_W = 8;

   logic                cmd_valid;
   logic                cmd_ready;
   logic [OP_W-1:0]     cmd_op;
   logic [DATA_W-1:0]   cmd_data;
   logic [OP_W-1:0]     pkt_op;
   logic [DATA_W-1:0]   pkt_data;
   logic [STATUS_W-1:0] status_in;
   logic                evt_valid;
   logic                evt_ready;
   logic [3:0]          evt_proc;
   logic [1:0]          evt_startstop;
   logic                evt_overflow;
   logic                cmd_error;

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, status_in, evt_ready,
      output cmd_ready, pkt_op, pkt_data, evt_valid, evt_proc, evt_startstop,
             evt_overflow, cmd_error
   );

   modport master (
      output cmd_valid, cmd_op, cmd_data, status_in, evt_ready,
      input  cmd_ready, pkt_op, pkt_data, evt_valid, evt_proc, evt_startstop,
             evt_overflow, cmd_error
   );
endinterface

// File: rtl/ttt_host_driver.sv
// ttt_host_driver: accepts host instructions, optionally waits for the device to
// reach stage 00, drives each instruction onto the device pins for one cycle, and
// queues start/stop events reported by the device in a small FIFO.
// Ports:
//   clock_fast : single rising-edge clock
//   reset      : asynchronous active-high reset
//   bus        : ttt_host_driver_if.slave (command, packet, status, event, error)
// Parameters:
//   EVT_DEPTH      : event FIFO depth, power of two >= 2
//   TIMEOUT_CYCLES : max WAIT cycles for a gated command (1..255)
module ttt_host_driver #(
   parameter int unsigned EVT_DEPTH      = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input logic              clock_fast,
   input logic              reset,
   ttt_host_driver_if.slave bus
);

   localparam int unsigned OP_W   = 4;
   localparam int unsigned DATA_W = 12;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned PTR_W  = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
   localparam int unsigned PTR_XW = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ISSUE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic [7:0]          status_q;
   logic                cmd_ready_q, cmd_ready_d;
   logic [OP_W-1:0]     pkt_op_q, pkt_op_d;
   logic [DATA_W-1:0]   pkt_data_q, pkt_data_d;
   logic                cmd_error_q, cmd_error_d;

   logic                is_issue_c;
   logic                is_gated_c;
   logic                is_nop_c;
   logic                accept_c;

   // Event FIFO storage and pointers (extra MSB separates full from empty)
   logic [3:0]          evt_proc_mem [EVT_DEPTH];
   logic [1:0]          evt_ss_mem   [EVT_DEPTH];
   logic [PTR_XW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_XW-1:0]   rd_ptr_q, rd_ptr_d;
   logic                evt_valid_q, evt_valid_d;
   logic                evt_overflow_q;
   logic                push_c, pop_c, full_c, push_ok_c;
   logic [PTR_W-1:0]    wr_idx_c, rd_idx_c;

   // Opcode classes: 1001-1111 issue directly, 0001/0010 gate on stage 00,
   // 0000 is a silent no-op, everything else is reserved.
   assign is_issue_c = bus.cmd_op[3] && (bus.cmd_op != 4'b1000);
   assign is_gated_c = (bus.cmd_op == 4'b0001) || (bus.cmd_op == 4'b0010);
   assign is_nop_c   = (bus.cmd_op == 4'b0000);
   assign accept_c   = bus.cmd_valid && cmd_ready_q;

   // Device status sampled once before any use
   always_ff @(posedge clock_fast or posedge reset) begin
      if (reset) status_q <= '0;
      else       status_q <= bus.status_in;
   end

   // Command FSM state and registered outputs
   always_ff @(posedge clock_fast or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         data_q      <= '0;
         wait_cnt_q  <= '0;
         cmd_ready_q <= 1'b1;
         pkt_op_q    <= '0;
         pkt_data_q  <= '0;
         cmd_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         data_q      <= data_d;
         wait_cnt_q  <= wait_cnt_d;
         cmd_ready_q <= cmd_ready_d;
         pkt_op_q    <= pkt_op_d;
         pkt_data_q  <= pkt_data_d;
         cmd_error_q <= cmd_error_d;
      end
   end

   // Next-state and next-output logic; packet registers load only when entering ISSUE
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      data_d      = data_q;
      wait_cnt_d  = wait_cnt_q;
      pkt_op_d    = '0;
      pkt_data_d  = '0;
      cmd_error_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               op_d   = bus.cmd_op;
               data_d = bus.cmd_data;
               if (is_issue_c) begin
                  state_d    = ST_ISSUE;
                  pkt_op_d   = bus.cmd_op;
                  pkt_data_d = bus.cmd_data;
               end else if (is_gated_c) begin
                  state_d    = ST_WAIT;
                  wait_cnt_d = '0;
               end else if (!is_nop_c) begin
                  cmd_error_d = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
            if (status_q[1:0] == 2'b00) begin
               state_d    = ST_ISSUE;
               pkt_op_d   = op_q;
               pkt_data_d = data_q;
            end else if (wait_cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
               // Counter tops out here, so it never wraps
               state_d     = ST_IDLE;
               wait_cnt_d  = '0;
               cmd_error_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      cmd_ready_d = (state_d == ST_IDLE);
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.pkt_op    = pkt_op_q;
   assign bus.pkt_data  = pkt_data_q;
   assign bus.cmd_error = cmd_error_q;

   // Event FIFO control; a full FIFO still accepts a push when the head pops in the same cycle
   assign wr_idx_c  = wr_ptr_q[PTR_W-1:0];
   assign rd_idx_c  = rd_ptr_q[PTR_W-1:0];
   assign push_c    = (status_q[3:2] != 2'b00) && (status_q[1:0] == 2'b11);
   assign pop_c     = evt_valid_q && bus.evt_ready;
   assign full_c    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx_c == rd_idx_c);
   assign push_ok_c = push_c && (!full_c || pop_c);
   assign wr_ptr_d  = wr_ptr_q + PTR_XW'(push_ok_c);
   assign rd_ptr_d  = rd_ptr_q + PTR_XW'(pop_c);
   assign evt_valid_d = (wr_ptr_d != rd_ptr_d);

   always_ff @(posedge clock_fast or posedge reset) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         evt_valid_q    <= 1'b0;
         evt_overflow_q <= 1'b0;
         for (int i = 0; i < int'(EVT_DEPTH); i++) begin
            evt_proc_mem[i] <= '0;
            evt_ss_mem[i]   <= '0;
         end
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         evt_valid_q <= evt_valid_d;
         if (push_ok_c) begin
            evt_proc_mem[wr_idx_c] <= status_q[7:4];
            evt_ss_mem[wr_idx_c]   <= status_q[3:2];
         end
         if (push_c && !push_ok_c) evt_overflow_q <= 1'b1;
      end
   end

   assign bus.evt_valid     = evt_valid_q;
   assign bus.evt_proc      = evt_valid_q ? evt_proc_mem[rd_idx_c] : 4'h0;
   assign bus.evt_startstop = evt_valid_q ? evt_ss_mem[rd_idx_c]   : 2'b00;
   assign bus.evt_overflow  = evt_overflow_q;

endmodule

// File: tb/tb_ttt_host_driver.sv
// tb_ttt_host_driver: directed self-checking bench for ttt_host_driver.
// Instance dut uses default parameters; dut_t8 uses TIMEOUT_CYCLES=8 for the timeout scenario.
module tb_ttt_host_driver;

   logic clock_fast = 1'b0;
   logic reset      = 1'b0;
   int   checks     = 0;
   int   errors     = 0;

   always #5 clock_fast = ~clock_fast;

   ttt_host_driver_if bus  ();
   ttt_host_driver_if bus8 ();

   ttt_host_driver dut (
      .clock_fast (clock_fast),
      .reset      (reset),
      .bus        (bus)
   );

   ttt_host_driver #(.TIMEOUT_CYCLES(8)) dut_t8 (
      .clock_fast (clock_fast),
      .reset      (reset),
      .bus        (bus8)
   );

   // Advance one rising edge and settle past it
   task automatic step();
      @(posedge clock_fast);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready); end
      checks++; if (bus.pkt_op !== 4'h0) begin errors++; $display("FAIL reset_pkt_op got=%h exp=0", bus.pkt_op); end
      checks++; if (bus.pkt_data !== 12'h000) begin errors++; $display("FAIL reset_pkt_data got=%h exp=000", bus.pkt_data); end
      checks++; if (bus.evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got=%0b exp=0", bus.evt_valid); end
      checks++; if (bus.evt_overflow !== 1'b0) begin errors++; $display("FAIL reset_evt_overflow got=%0b exp=0", bus.evt_overflow); end
      checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL reset_cmd_error got=%0b exp=0", bus.cmd_error); end
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_program();
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL prog_ready_before got=%0b exp=1", bus.cmd_ready); end
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b1001; bus.cmd_data = 12'h32A;
      step();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.pkt_op !== 4'b1001) begin errors++; $display("FAIL prog_pkt_op got=%h exp=9", bus.pkt_op); end
      checks++; if (bus.pkt_data !== 12'h32A) begin errors++; $display("FAIL prog_pkt_data got=%h exp=32a", bus.pkt_data); end
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL prog_ready_issue got=%0b exp=0", bus.cmd_ready); end
      step();
      checks++; if (bus.pkt_op !== 4'h0 || bus.pkt_data !== 12'h000) begin errors++; $display("FAIL prog_pkt_clear got=%h/%h exp=0/000", bus.pkt_op, bus.pkt_data); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL prog_ready_after got=%0b exp=1", bus.cmd_ready); end
   endtask

   task automatic test_back_to_back();
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b1100; bus.cmd_data = 12'h111;
      step();
      checks++; if (bus.pkt_op !== 4'b1100 || bus.pkt_data !== 12'h111) begin errors++; $display("FAIL b2b_first got=%h/%h exp=c/111", bus.pkt_op, bus.pkt_data); end
      bus.cmd_op = 4'b1111; bus.cmd_data = 12'hABC;
      step();
      // Second command offered during ISSUE must not be taken yet
      checks++; if (bus.pkt_op !== 4'h0 || bus.pkt_data !== 12'h000) begin errors++; $display("FAIL b2b_gap got=%h/%h exp=0/000", bus.pkt_op, bus.pkt_data); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap_ready got=%0b exp=1", bus.cmd_ready); end
      step();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.pkt_op !== 4'b1111 || bus.pkt_data !== 12'hABC) begin errors++; $display("FAIL b2b_second got=%h/%h exp=f/abc", bus.pkt_op, bus.pkt_data); end
      step();
   endtask

   task automatic test_gated();
      bus.status_in = 8'h01;
      step();
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0001; bus.cmd_data = 12'h563;
      step();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL gated_ready_wait got=%0b exp=0", bus.cmd_ready); end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (bus.pkt_op !== 4'h0 || bus.cmd_error !== 1'b0) begin errors++; $display("FAIL gated_hold[%0d] pkt_op=%h err=%0b exp=0/0", i, bus.pkt_op, bus.cmd_error); end
      end
      bus.status_in = 8'h00;
      step();
      checks++; if (bus.pkt_op !== 4'h0) begin errors++; $display("FAIL gated_early got=%h exp=0", bus.pkt_op); end
      step();
      checks++; if (bus.pkt_op !== 4'b0001 || bus.pkt_data !== 12'h563) begin errors++; $display("FAIL gated_issue got=%h/%h exp=1/563", bus.pkt_op, bus.pkt_data); end
      checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL gated_no_err got=%0b exp=0", bus.cmd_error); end
      step();
      checks++; if (bus.pkt_op !== 4'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL gated_done pkt_op=%h ready=%0b exp=0/1", bus.pkt_op, bus.cmd_ready); end
   endtask

   task automatic test_timeout();
      bus8.status_in = 8'h02;
      step();
      bus8.cmd_valid = 1'b1; bus8.cmd_op = 4'b0010; bus8.cmd_data = 12'h0FF;
      step();
      bus8.cmd_valid = 1'b0;
      checks++; if (bus8.cmd_ready !== 1'b0) begin errors++; $display("FAIL tmo_ready_wait got=%0b exp=0", bus8.cmd_ready); end
      for (int i = 1; i <= 7; i++) begin
         step();
         checks++; if (bus8.cmd_error !== 1'b0 || bus8.pkt_op !== 4'h0) begin errors++; $display("FAIL tmo_wait[%0d] err=%0b pkt_op=%h exp=0/0", i, bus8.cmd_error, bus8.pkt_op); end
      end
      step();
      checks++; if (bus8.cmd_error !== 1'b1) begin errors++; $display("FAIL tmo_err got=%0b exp=1", bus8.cmd_error); end
      checks++; if (bus8.cmd_ready !== 1'b1) begin errors++; $display("FAIL tmo_ready got=%0b exp=1", bus8.cmd_ready); end
      checks++; if (bus8.pkt_op !== 4'h0 || bus8.pkt_data !== 12'h000) begin errors++; $display("FAIL tmo_pkt got=%h/%h exp=0/000", bus8.pkt_op, bus8.pkt_data); end
      step();
      checks++; if (bus8.cmd_error !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse got=%0b exp=0", bus8.cmd_error); end
      bus8.status_in = 8'h00;
   endtask

   task automatic test_reserved();
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0101; bus.cmd_data = 12'h777;
      step();
      checks++; if (bus.cmd_error !== 1'b1) begin errors++; $display("FAIL rsv_0101_err got=%0b exp=1", bus.cmd_error); end
      checks++; if (bus.pkt_op !== 4'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rsv_0101_state pkt_op=%h ready=%0b exp=0/1", bus.pkt_op, bus.cmd_ready); end
      bus.cmd_op = 4'b1000;
      step();
      checks++; if (bus.cmd_error !== 1'b1 || bus.pkt_op !== 4'h0) begin errors++; $display("FAIL rsv_1000 err=%0b pkt_op=%h exp=1/0", bus.cmd_error, bus.pkt_op); end
      bus.cmd_op = 4'b0000;
      step();
      checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL nop_err got=%0b exp=0", bus.cmd_error); end
      bus.cmd_valid = 1'b0;
      step();
      checks++; if (bus.cmd_error !== 1'b0 || bus.pkt_op !== 4'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL nop_after err=%0b pkt_op=%h ready=%0b exp=0/0/1", bus.cmd_error, bus.pkt_op, bus.cmd_ready); end
   endtask

   task automatic test_events_overflow();
      int n;
      bus.evt_ready = 1'b0;
      bus.status_in = 8'h77;
      for (int i = 0; i < 5; i++) step();
      bus.status_in = 8'h00;
      step();
      step();
      checks++; if (bus.evt_overflow !== 1'b1) begin errors++; $display("FAIL evt_ovf_set got=%0b exp=1", bus.evt_overflow); end
      checks++; if (bus.evt_valid !== 1'b1) begin errors++; $display("FAIL evt_valid got=%0b exp=1", bus.evt_valid); end
      n = 0;
      bus.evt_ready = 1'b1;
      for (int k = 0; k < 10 && bus.evt_valid === 1'b1; k++) begin
         checks++; if (bus.evt_proc !== 4'h7 || bus.evt_startstop !== 2'b01) begin errors++; $display("FAIL evt_head[%0d] got=%h/%b exp=7/01", k, bus.evt_proc, bus.evt_startstop); end
         step();
         n++;
      end
      bus.evt_ready = 1'b0;
      checks++; if (n !== 4) begin errors++; $display("FAIL evt_count got=%0d exp=4", n); end
      checks++; if (bus.evt_proc !== 4'h0 || bus.evt_startstop !== 2'b00) begin errors++; $display("FAIL evt_empty_head got=%h/%b exp=0/00", bus.evt_proc, bus.evt_startstop); end
      checks++; if (bus.evt_overflow !== 1'b1) begin errors++; $display("FAIL evt_ovf_sticky got=%0b exp=1", bus.evt_overflow); end
   endtask

   task automatic test_events_pop_when_full();
      int n;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      step();
      checks++; if (bus.evt_overflow !== 1'b0) begin errors++; $display("FAIL evt_ovf_cleared got=%0b exp=0", bus.evt_overflow); end
      bus.status_in = 8'h77;
      for (int i = 0; i < 5; i++) step();
      // FIFO is full here; the 5th push coincides with a pop
      bus.status_in = 8'h00;
      bus.evt_ready = 1'b1;
      step();
      bus.evt_ready = 1'b0;
      step();
      checks++; if (bus.evt_overflow !== 1'b0) begin errors++; $display("FAIL evt_popfull_ovf got=%0b exp=0", bus.evt_overflow); end
      n = 0;
      bus.evt_ready = 1'b1;
      for (int k = 0; k < 10 && bus.evt_valid === 1'b1; k++) begin
         step();
         n++;
      end
      bus.evt_ready = 1'b0;
      checks++; if (n !== 4) begin errors++; $display("FAIL evt_popfull_count got=%0d exp=4", n); end
   endtask

   task automatic test_reset_mid_wait();
      bus.status_in = 8'h01;
      step();
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b0001; bus.cmd_data = 12'h5AA;
      step();
      bus.cmd_valid = 1'b0;
      step();
      step();
      checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL rstw_in_wait got=%0b exp=0", bus.cmd_ready); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.cmd_ready !== 1'b1 || bus.pkt_op !== 4'h0 || bus.pkt_data !== 12'h000) begin errors++; $display("FAIL rstw_async ready=%0b pkt=%h/%h exp=1/0/000", bus.cmd_ready, bus.pkt_op, bus.pkt_data); end
      checks++; if (bus.cmd_error !== 1'b0 || bus.evt_valid !== 1'b0) begin errors++; $display("FAIL rstw_async_flags err=%0b evt=%0b exp=0/0", bus.cmd_error, bus.evt_valid); end
      step();
      reset = 1'b0;
      bus.status_in = 8'h00;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (bus.pkt_op !== 4'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_after[%0d] pkt_op=%h ready=%0b exp=0/1", i, bus.pkt_op, bus.cmd_ready); end
      end
   endtask

   task automatic test_reset_mid_issue();
      bus.cmd_valid = 1'b1; bus.cmd_op = 4'b1001; bus.cmd_data = 12'h3AA;
      step();
      bus.cmd_valid = 1'b0;
      checks++; if (bus.pkt_op !== 4'b1001) begin errors++; $display("FAIL rsti_issue got=%h exp=9", bus.pkt_op); end
      reset = 1'b1;
      #1;
      checks++; if (bus.pkt_op !== 4'h0 || bus.pkt_data !== 12'h000) begin errors++; $display("FAIL rsti_async got=%h/%h exp=0/000", bus.pkt_op, bus.pkt_data); end
      step();
      reset = 1'b0;
      step();
      checks++; if (bus.pkt_op !== 4'h0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rsti_after pkt_op=%h ready=%0b exp=0/1", bus.pkt_op, bus.cmd_ready); end
   endtask

   initial begin
      bus.cmd_valid  = 1'b0; bus.cmd_op  = '0; bus.cmd_data  = '0;
      bus.status_in  = '0;   bus.evt_ready  = 1'b0;
      bus8.cmd_valid = 1'b0; bus8.cmd_op = '0; bus8.cmd_data = '0;
      bus8.status_in = '0;   bus8.evt_ready = 1'b0;
      #2;
      test_reset();
      test_program();
      test_back_to_back();
      test_gated();
      test_timeout();
      test_reserved();
      test_events_overflow();
      test_events_pop_when_full();
      test_reset_mid_wait();
      test_reset_mid_issue();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
